alu_seq_nbit: RTL and testbench
===============================

Name: alu_seq_nbit

Overview:
- Parametrised, registered successor to the 32-bit combinational MiniMIPS ALU.
- Keeps the same 3-bit operation encoding.
- Adds result flags: zero, signed overflow and carry.
- Adds a real multi-cycle iterative multiply (shift-add) producing a 2*WIDTH product, with a start/busy/done handshake.
- Sits between the decode/register-read stage and writeback; the MULT result feeds HI/LO.

Parameters:
- WIDTH, 32, operand and result width; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width; derived, never overridden.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  operation request; sampled only when busy=0
- select  input  3  opcode: 000 AND, 001 ADD, 010 SUB, 011 XOR, 100 NOR, 101 OR, 110 SLT, 111 MULT
- value1  input  WIDTH  operand A
- value2  input  WIDTH  operand B
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse: result, result_hi and flags updated
- result  output  WIDTH  logic/arith result; low half of the product for MULT
- result_hi  output  WIDTH  high half of the product for MULT; 0 for every other op
- zero  output  1  result == 0 (for MULT: full 2*WIDTH product == 0)
- carry  output  1  ADD carry-out; SUB no-borrow (value1 >= value2 unsigned); 0 otherwise
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise

Behaviour:
- Reset: one clock sampling reset=1 clears every output and internal register. FSM goes to IDLE; busy=done=0; result=result_hi=0; zero=carry=overflow=0.
- Reset has priority over start and aborts an in-flight MULT: no done pulse, result unchanged from its reset value.
- FSM states: IDLE, MUL.
- IDLE, start=1, select!=111:
  - Compute combinationally, register at the same edge.
  - done=1 in the following cycle; stay IDLE. Latency 1.
  - Back-to-back starts give done on consecutive cycles.
- IDLE, start=1, select=111:
  - Latch value1 (multiplicand) and value2 (multiplier).
  - Clear the 2*WIDTH accumulator, load counter=WIDTH, go to MUL, busy=1.
- MUL, each cycle:
  - If multiplier LSB=1, add multiplicand to the upper half of the accumulator (WIDTH+1-bit add, carry kept).
  - Shift {carry, acc} right by 1, shift the multiplier right, decrement the counter.
- MUL, counter reaches 1 at an edge: the final iteration completes there.
  - Load result/result_hi; set zero; go to IDLE.
  - busy=0 and done=1 in the next cycle.
  - Start sampled at edge k gives done high in cycle k+WIDTH+1.
- MULT is unsigned; result_hi:result is the exact 2*WIDTH product.
- start while busy=1 is ignored (not queued). Operand and select changes during MUL have no effect.
- Outputs hold their last value between operations. done is high for exactly one cycle per accepted op.
- Arithmetic rules:
  - ADD/SUB are modulo 2^WIDTH.
  - SUB is value1 + ~value2 + 1; carry is the carry-out of that sum.
  - overflow is the operand/result sign mismatch (ADD: same-sign inputs, different-sign result; SUB: different-sign inputs, result sign != value1 sign).
  - SLT is signed: result = {WIDTH-1 zeros, (value1 <s value2)}.
- Boundaries:
  - MULT by 0, or of 0, still takes WIDTH cycles.
  - MULT all-ones × all-ones = 2^(2W) - 2^(W+1) + 1 with no overflow lost.
  - Start in the same cycle done is high is accepted; busy=0 then.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_AND..OP_MULT (3'b000..3'b111);
  - the FSM state encoding (ST_IDLE, ST_MUL).
- One sub-module, mult_seq_nbit (WIDTH parameter), holds the iterative shift-add datapath and counter with a start/done interface.
- The top level holds the single-cycle ops, the flags, the FSM and the output registers.

Test Plan:
- Reset mid-MULT: start MULT 7×9 (WIDTH=32), assert reset at cycle 5 -> busy=0 and result=0 next cycle, no done pulse ever appears.
- ADD overflow, WIDTH=32: 0x7FFFFFFF+1 -> result=0x80000000, overflow=1, carry=0, done at k+1. Then 0xFFFFFFFF+1 -> result=0, zero=1, carry=1, overflow=0.
- SUB/SLT: SUB 5−7 -> 0xFFFFFFFE, carry=0. SLT 0xFFFFFFFF (−1) vs 1 -> result=1. SLT 1 vs 0xFFFFFFFF -> 0.
- MULT latency, WIDTH=32: 0xFFFFFFFF×0xFFFFFFFF -> result_hi=0xFFFFFFFE, result=0x00000001. busy is high for cycles k+1..k+32; done is high in cycle k+33 only.
- Ignored start: during MULT 3×4 (WIDTH=8), pulse start with ADD 1+1 -> the MULT still completes with result=12, result_hi=0. No ADD result appears and there is only one done.
- Logic ops back-to-back, WIDTH=8: AND/OR/XOR/NOR on 0xF0, 0x3C in consecutive cycles -> 0x30, 0xFC, 0xCC, 0x03, with done on 4 consecutive cycles.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode encoding and FSM states shared by the sequential ALU
// Rev 1.0 : initial release
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_MULT = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_seq_nbit.sv
`default_nettype none
// ============================================================================
// mult_seq_nbit : unsigned iterative shift-add multiplier, one bit per cycle
// Rev 1.0 : initial release
// ============================================================================
module mult_seq_nbit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;

  // The multiplier lives in the low half of the accumulator: its LSB is
  // always r_acc[0], and product bits shift in from the top as it drains.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_mcand <= i_multiplicand;
      r_acc   <= {{WIDTH{1'b0}}, i_multiplier};
      r_cnt   <= c_cnt_init;
    end else if (r_cnt != '0) begin
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last    = (r_cnt == CNT_W'(1));
  assign o_product = w_acc_next;

endmodule
`default_nettype wire

// File: rtl/alu_seq_nbit.sv
`default_nettype none
// ============================================================================
// alu_seq_nbit : registered N-bit ALU with flags and multi-cycle unsigned MULT
// Rev 1.0 : initial release
// ============================================================================
module alu_seq_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  state_t r_state;
  state_t w_state_next;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_alu_start;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_product;

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;

  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_done;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_mul_start = w_accept && (select == OP_MULT);
  assign w_alu_start = w_accept && (select != OP_MULT);

  mult_seq_nbit #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk            (clock),
    .rst            (reset),
    .i_start        (w_mul_start),
    .i_multiplicand (value1),
    .i_multiplier   (value2),
    .o_last         (w_mul_last),
    .o_product      (w_product)
  );

  // SUB is value1 + ~value2 + 1, so its carry-out means "no borrow".
  assign w_add = {1'b0, value1} + {1'b0, value2};
  assign w_sub = {1'b0, value1} + {1'b0, ~value2} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (select)
      OP_AND: w_res = value1 & value2;
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (value1[WIDTH-1] == value2[WIDTH-1]) &&
                  (w_add[WIDTH-1] != value1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (value1[WIDTH-1] != value2[WIDTH-1]) &&
                  (w_sub[WIDTH-1] != value1[WIDTH-1]);
      end
      OP_XOR: w_res = value1 ^ value2;
      OP_NOR: w_res = ~(value1 | value2);
      OP_OR:  w_res = value1 | value2;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(value1) < $signed(value2))};
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
      ST_MUL:  if (w_mul_last)  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_done      <= 1'b0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_alu_start) begin
        r_result    <= w_res;
        r_result_hi <= '0;
        r_zero      <= (w_res == '0);
        r_carry     <= w_carry;
        r_ovf       <= w_ovf;
        r_done      <= 1'b1;
      end else if ((r_state == ST_MUL) && w_mul_last) begin
        r_result    <= w_product[WIDTH-1:0];
        r_result_hi <= w_product[2*WIDTH-1:WIDTH];
        r_zero      <= (w_product == '0);
        r_carry     <= 1'b0;
        r_ovf       <= 1'b0;
        r_done      <= 1'b1;
      end
    end
  end

  assign busy      = (r_state == ST_MUL);
  assign done      = r_done;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_nbit.sv
`default_nettype none
// ============================================================================
// tb_alu_seq_nbit : scoreboard bench for alu_seq_nbit against an arithmetic model
// Rev 1.0 : initial release
// ============================================================================
module tb_alu_seq_nbit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   select;
  logic [W-1:0] value1;
  logic [W-1:0] value2;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         carry;
  logic         overflow;

  always #5 clock = ~clock;

  alu_seq_nbit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .select    (select),
    .value1    (value1),
    .value2    (value2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         carry;
    logic         ovf;
    int           due;
    string        tag;
  } exp_t;

  exp_t q[$];
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   busy_lo = -1;
  int   busy_hi = -2;
  bit   mon_en  = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain wide/signed arithmetic on whole numbers.
  function automatic exp_t model(input logic [2:0] sel, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t           e;
    longint         sa;
    longint         sb;
    longint         s;
    longint         lim;
    logic [2*W-1:0] wide;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    e.res = '0; e.hi = '0; e.carry = 1'b0; e.ovf = 1'b0; e.due = 0; e.tag = "";
    case (sel)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      OP_NOR: e.res = ~(a | b);
      OP_ADD: begin
        wide    = {{W{1'b0}}, a} + {{W{1'b0}}, b};
        e.res   = wide[W-1:0];
        e.carry = (wide >> W) != 0;
        s       = sa + sb;
        e.ovf   = (s >= lim) || (s < -lim);
      end
      OP_SUB: begin
        e.res   = a - b;
        e.carry = (a >= b);
        s       = sa - sb;
        e.ovf   = (s >= lim) || (s < -lim);
      end
      OP_SLT: e.res = (sa < sb) ? W'(1) : W'(0);
      default: begin
        wide  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = wide[W-1:0];
        e.hi  = wide[2*W-1:W];
      end
    endcase
    e.zero = (e.res == '0) && (e.hi == '0);
    return e;
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      if (done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.tag, "_cycle"},  cyc,       e.due);
          chk({e.tag, "_result"}, result,    e.res);
          chk({e.tag, "_hi"},     result_hi, e.hi);
          chk({e.tag, "_zero"},   zero,      e.zero);
          chk({e.tag, "_carry"},  carry,     e.carry);
          chk({e.tag, "_ovf"},    overflow,  e.ovf);
        end
      end
    end
  end

  // Issue one op; for MULT, scramble inputs while busy and wait for its done.
  task automatic issue(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag, input bit poke = 1'b0);
    exp_t e;
    int   n;
    e     = model(sel, a, b);
    e.tag = tag;
    e.due = (sel == OP_MULT) ? cyc + 1 + W : cyc + 1;
    if (sel == OP_MULT) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + W;
    end
    q.push_back(e);
    start = 1'b1; select = sel; value1 = a; value2 = b;
    @(negedge clock);
    start = 1'b0;
    if (sel == OP_MULT) begin
      n = 0;
      while (cyc < e.due) begin
        start  = 1'b0;
        value1 = $urandom; value2 = $urandom; select = 3'($urandom);
        if (poke && n == 3) begin
          start = 1'b1; select = OP_ADD; value1 = 1; value2 = 1;
        end
        n++;
        @(negedge clock);
      end
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 4 * W) begin
      @(negedge clock);
      guard++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending ops required 0", q.size());
      q.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] c;
    case ($urandom_range(0, 7))
      0: c = '0;
      1: c = '1;
      2: c = {1'b0, {(W-1){1'b1}}};
      3: c = {1'b1, {(W-1){1'b0}}};
      4: c = W'(1);
      default: c = $urandom;
    endcase
    return c;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; select = '0; value1 = '0; value2 = '0;
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_hi", result_hi, 0);
    chk("reset_flags", {zero, carry, overflow}, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, "add_ovf");
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, "add_wrap");
    issue(OP_SUB, 32'd5, 32'd7, "sub");
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h1, "slt_neg");
    issue(OP_SLT, 32'h1, 32'hFFFF_FFFF, "slt_pos");
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    issue(OP_MULT, 32'h0, 32'h1234, "mul_zero");
    issue(OP_AND, 32'hF0, 32'h3C, "and");
    issue(OP_OR,  32'hF0, 32'h3C, "or");
    issue(OP_XOR, 32'hF0, 32'h3C, "xor");
    issue(OP_NOR, 32'hF0, 32'h3C, "nor");
    issue(OP_MULT, 32'd3, 32'd4, "mul_poked", 1'b1);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) @(negedge clock);
      issue(3'($urandom), pick(), pick(), "rnd");
    end
    drain();

    // Abort a MULT with reset: no done may follow and outputs return to zero.
    busy_lo = cyc + 1;
    busy_hi = cyc + W;
    start = 1'b1; select = OP_MULT; value1 = 32'd7; value2 = 32'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset   = 1'b1;
    busy_hi = cyc;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_hi", result_hi, 0);
    chk("abort_done", done, 0);
    repeat (W + 5) @(negedge clock);

    issue(OP_ADD, 32'd2, 32'd3, "post_reset");
    drain();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion required $finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
